// File: rtl/pc_stack.sv
// pc_stack: WIDTH-bit program counter with an integrated DEPTH-entry
// hardware return stack for CALL/RET.
//
// Parameters:
//   WIDTH      - counter and stack entry width in bits
//   DEPTH      - number of return-stack entries (>= 1)
//   RESET_ADDR - value loaded into the PC on RST_N low or CLR
//
// Ports:
//   CLK   in   rising-edge clock
//   RST_N in   asynchronous active-low reset
//   IN    in   jump/call target address
//   CLR   in   synchronous clear (PC, SP, ERR)
//   RET   in   pop top of stack into PC
//   CALL  in   push OUT+1, jump to IN
//   LOAD  in   jump to IN
//   INC   in   PC <= PC + 1
//   OUT   out  current PC (registered)
//   SP    out  number of valid stack entries
//   FULL  out  SP == DEPTH
//   EMPTY out  SP == 0
//   ERR   out  sticky overflow/underflow flag
//
// Strobe priority: CLR > RET > CALL > LOAD > INC > hold.

module pc_stack #(
    parameter int unsigned     WIDTH      = 16,
    parameter int unsigned     DEPTH      = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [WIDTH-1:0]           IN,
    input  logic                       CLR,
    input  logic                       RET,
    input  logic                       CALL,
    input  logic                       LOAD,
    input  logic                       INC,
    output logic [WIDTH-1:0]           OUT,
    output logic [$clog2(DEPTH+1)-1:0] SP,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic                       ERR
);

    localparam int unsigned SPW  = $clog2(DEPTH + 1);
    localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CALL,
        OP_RET,
        OP_CLR
    } op_t;

    op_t              op;
    logic [WIDTH-1:0] pc_plus1;
    logic [IDXW-1:0]  push_idx;
    logic [IDXW-1:0]  pop_idx;
    logic [WIDTH-1:0] stack_mem [DEPTH];

    // Exactly one action per cycle; lower-priority strobes are dropped.
    always_comb begin
        op = OP_HOLD;
        if (CLR)       op = OP_CLR;
        else if (RET)  op = OP_RET;
        else if (CALL) op = OP_CALL;
        else if (LOAD) op = OP_LOAD;
        else if (INC)  op = OP_INC;
    end

    assign pc_plus1 = OUT + WIDTH'(1);

    // Indices only matter when the push/pop is legal (SP < DEPTH / SP > 0),
    // so truncation at the boundary values is harmless.
    assign push_idx = IDXW'(SP);
    assign pop_idx  = IDXW'(SP - SPW'(1));

    assign FULL  = (SP == SPW'(DEPTH));
    assign EMPTY = (SP == '0);

    // Return-address storage carries no reset. The RST_N term keeps an edge
    // that lands while reset is held from writing an entry.
    always_ff @(posedge CLK) begin
        if (RST_N && (op == OP_CALL) && !FULL) begin
            stack_mem[push_idx] <= pc_plus1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT <= RESET_ADDR;
            SP  <= '0;
            ERR <= 1'b0;
        end else begin
            unique case (op)
                OP_CLR: begin
                    OUT <= RESET_ADDR;
                    SP  <= '0;
                    ERR <= 1'b0;
                end
                OP_RET: begin
                    if (!EMPTY) begin
                        OUT <= stack_mem[pop_idx];
                        SP  <= SP - SPW'(1);
                    end else begin
                        ERR <= 1'b1;
                    end
                end
                OP_CALL: begin
                    if (!FULL) begin
                        OUT <= IN;
                        SP  <= SP + SPW'(1);
                    end else begin
                        ERR <= 1'b1;
                    end
                end
                OP_LOAD: OUT <= IN;
                OP_INC:  OUT <= pc_plus1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

    logic        CLK;
    logic        RST_N;
    logic [15:0] IN;
    logic        CLR, RET, CALL, LOAD, INC;
    logic [15:0] OUT;
    logic [3:0]  SP;
    logic        FULL, EMPTY, ERR;

    int total = 0;
    int bad   = 0;

    pc_stack #(
        .WIDTH      (16),
        .DEPTH      (8),
        .RESET_ADDR (16'h0000)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .IN    (IN),
        .CLR   (CLR),
        .RET   (RET),
        .CALL  (CALL),
        .LOAD  (LOAD),
        .INC   (INC),
        .OUT   (OUT),
        .SP    (SP),
        .FULL  (FULL),
        .EMPTY (EMPTY),
        .ERR   (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        clr, ret, call, load, inc;
        logic [15:0] in;
        logic [15:0] out;
        logic [3:0]  sp;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input logic clr, input logic ret,
                                input logic call, input logic load, input logic inc,
                                input logic [15:0] in, input logic [15:0] out,
                                input logic [3:0] sp, input logic err);
        vec_t v;
        v.name = name; v.clr = clr; v.ret = ret; v.call = call; v.load = load; v.inc = inc;
        v.in = in; v.out = out; v.sp = sp; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [15:0] out,
                               input logic [3:0] sp, input logic err);
        check({name, "_out"},   32'(OUT),   32'(out));
        check({name, "_sp"},    32'(SP),    32'(sp));
        check({name, "_err"},   32'(ERR),   32'(err));
        check({name, "_full"},  32'(FULL),  32'(sp == 4'd8));
        check({name, "_empty"}, 32'(EMPTY), 32'(sp == 4'd0));
    endtask

    task automatic strobes_off();
        CLR = 0; RET = 0; CALL = 0; LOAD = 0; INC = 0;
    endtask

    task automatic run_vecs(input int first, input int last);
        for (int i = first; i < last; i++) begin
            CLR = vecs[i].clr; RET = vecs[i].ret; CALL = vecs[i].call;
            LOAD = vecs[i].load; INC = vecs[i].inc; IN = vecs[i].in;
            @(posedge CLK);
            #1;
            check_state($sformatf("v%0d_%s", i, vecs[i].name), vecs[i].out, vecs[i].sp, vecs[i].err);
        end
        strobes_off();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int split;

    initial begin
        // Phase 1: count and jump.
        add("inc1",  0,0,0,0,1, 16'h0000, 16'h0001, 0, 0);
        add("inc2",  0,0,0,0,1, 16'h0000, 16'h0002, 0, 0);
        add("inc3",  0,0,0,0,1, 16'h0000, 16'h0003, 0, 0);
        add("hold1", 0,0,0,0,0, 16'h0000, 16'h0003, 0, 0);
        add("hold2", 0,0,0,0,0, 16'h0000, 16'h0003, 0, 0);
        add("load",  0,0,0,1,0, 16'h1234, 16'h1234, 0, 0);
        add("inc4",  0,0,0,0,1, 16'h0000, 16'h1235, 0, 0);
        split = vecs.size();
        // Phase 2 (after async reset): nesting.
        add("ld10",  0,0,0,1,0, 16'h0010, 16'h0010, 0, 0);
        add("call1", 0,0,1,0,0, 16'h0100, 16'h0100, 1, 0);
        add("inc5",  0,0,0,0,1, 16'h0000, 16'h0101, 1, 0);
        add("inc6",  0,0,0,0,1, 16'h0000, 16'h0102, 1, 0);
        add("call2", 0,0,1,0,0, 16'h0200, 16'h0200, 2, 0);
        add("ret1",  0,1,0,0,0, 16'h0000, 16'h0103, 1, 0);
        add("ret2",  0,1,0,0,0, 16'h0000, 16'h0011, 0, 0);
        add("inchg", 0,0,0,0,0, 16'hBEEF, 16'h0011, 0, 0);
        add("undfl", 0,1,0,0,0, 16'h0000, 16'h0011, 0, 1);
        add("lderr", 0,0,0,1,0, 16'h0020, 16'h0020, 0, 1);
        add("clr1",  1,0,0,0,0, 16'h0000, 16'h0000, 0, 0);
        // Fill: pushes 0x0001 then 0x1001..0x1007.
        for (int i = 0; i < 8; i++)
            add($sformatf("fill%0d", i), 0,0,1,0,0, 16'(16'h1000 + i), 16'(16'h1000 + i), 4'(i + 1), 0);
        add("ovfl",  0,0,1,0,0, 16'hAAAA, 16'h1007, 8, 1);
        for (int i = 7; i >= 1; i--)
            add($sformatf("pop%0d", i), 0,1,0,0,0, 16'h0000, 16'(16'h1000 + i), 4'(i), 1);
        add("pop0",  0,1,0,0,0, 16'h0000, 16'h0001, 0, 1);
        add("undf2", 0,1,0,0,0, 16'h0000, 16'h0001, 0, 1);
        add("clr2",  1,0,0,0,0, 16'h0000, 16'h0000, 0, 0);
        // Priority.
        add("call3", 0,0,1,0,0, 16'h0300, 16'h0300, 1, 0);
        add("callret",0,1,1,0,0,16'h0400, 16'h0001, 0, 0);
        add("clrcall",1,0,1,0,0,16'h0500, 16'h0000, 0, 0);
        add("nopush",0,1,0,0,0, 16'h0000, 16'h0000, 0, 1);
        add("clr3",  1,0,0,0,0, 16'h0000, 16'h0000, 0, 0);
        add("ldinc", 0,0,0,1,1, 16'h0050, 16'h0050, 0, 0);
        add("call4", 0,0,1,0,0, 16'h0060, 16'h0060, 1, 0);
        add("retinc",0,1,0,0,1, 16'h0000, 16'h0051, 0, 0);
        // Wrap.
        add("ldff",  0,0,0,1,0, 16'hFFFF, 16'hFFFF, 0, 0);
        add("wrap",  0,0,0,0,1, 16'h0000, 16'h0000, 0, 0);
        add("ldff2", 0,0,0,1,0, 16'hFFFF, 16'hFFFF, 0, 0);
        add("callw", 0,0,1,0,0, 16'h0005, 16'h0005, 1, 0);
        add("retw",  0,1,0,0,0, 16'h0000, 16'h0000, 0, 0);
        add("undf3", 0,1,0,0,0, 16'h0000, 16'h0000, 0, 1);

        IN = '0;
        strobes_off();
        RST_N = 1'b0;
        #2;
        check_state("rst", 16'h0000, 0, 0);
        #1 RST_N = 1'b1;

        run_vecs(0, split);

        // Async reset mid-cycle with a pending INC.
        INC = 1'b1;
        #2 RST_N = 1'b0;
        #1;
        check_state("arst_now", 16'h0000, 0, 0);
        @(posedge CLK);
        #1;
        check_state("arst_held", 16'h0000, 0, 0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check_state("arst_rel", 16'h0001, 0, 0);
        strobes_off();
        LOAD = 1'b0;
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;

        run_vecs(split, vecs.size());

        // ERR from underflow cleared by async reset.
        #2 RST_N = 1'b0;
        #1;
        check_state("arst_err", 16'h0000, 0, 0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
